// File: rtl/hood_status_display.sv
// Range-hood panel display driver: 8-digit multiplexed 7-segment scan, mode LEDs,
// blinking reminder LED and a BCD seconds countdown that mirrors the controller.
module hood_status_display #(
    parameter int unsigned SEC_DIV  = 100000000,
    parameter int unsigned SCAN_DIV = 100000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  mode,
    input  logic        countdown,
    input  logic        cleaning_reminder,
    output logic [7:0]  seg,
    output logic [7:0]  an,
    output logic [3:0]  led_mode,
    output logic        led_reminder,
    output logic [11:0] cd_bcd
);

    localparam int unsigned SEC_W  = (SEC_DIV > 1) ? $clog2(SEC_DIV) : 1;
    localparam int unsigned SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [SEC_W-1:0]  SEC_LAST  = SEC_W'(SEC_DIV - 1);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

    localparam logic [6:0] GLYPH_C     = 7'b0111001;
    localparam logic [6:0] GLYPH_DASH  = 7'b1000000;
    localparam logic [6:0] GLYPH_BLANK = 7'b0000000;

    logic              cd_d;
    logic [SEC_W-1:0]  sec_cnt;
    logic [SEC_W-1:0]  blink_cnt;
    logic              blink;
    logic [SCAN_W-1:0] scan_cnt;
    logic [2:0]        idx;

    logic              cd_rise;
    logic              sec_tick;
    logic              blink_wrap;
    logic              scan_wrap;
    logic [11:0]       cd_next;
    logic [SEC_W-1:0]  sec_next;
    logic [7:0]        seg_next;
    logic [3:0]        led_mode_next;
    logic [6:0]        mode_glyph;

    function automatic logic [6:0] digit_glyph(input logic [3:0] d);
        case (d)
            4'd0:    digit_glyph = 7'b0111111;
            4'd1:    digit_glyph = 7'b0000110;
            4'd2:    digit_glyph = 7'b1011011;
            4'd3:    digit_glyph = 7'b1001111;
            4'd4:    digit_glyph = 7'b1100110;
            4'd5:    digit_glyph = 7'b1101101;
            4'd6:    digit_glyph = 7'b1111101;
            4'd7:    digit_glyph = 7'b0000111;
            4'd8:    digit_glyph = 7'b1111111;
            4'd9:    digit_glyph = 7'b1101111;
            default: digit_glyph = GLYPH_BLANK;
        endcase
    endfunction

    // Three-digit BCD decrement; borrow ripples ones -> tens -> hundreds.
    function automatic logic [11:0] bcd_dec(input logic [11:0] v);
        logic [3:0] h, t, o;
        {h, t, o} = v;
        if (o != 4'd0) begin
            o = o - 4'd1;
        end else begin
            o = 4'd9;
            if (t != 4'd0) begin
                t = t - 4'd1;
            end else begin
                t = 4'd9;
                h = h - 4'd1;
            end
        end
        bcd_dec = {h, t, o};
    endfunction

    always_comb begin
        cd_rise    = countdown & ~cd_d;
        sec_tick   = countdown && (sec_cnt == SEC_LAST);
        blink_wrap = (blink_cnt == SEC_LAST);
        scan_wrap  = (scan_cnt == SCAN_LAST);

        cd_next  = cd_bcd;
        sec_next = sec_cnt;
        if (!countdown) begin
            cd_next  = 12'h000;
            sec_next = '0;
        end else if (cd_rise) begin
            cd_next  = (mode == 3'b111) ? 12'h180 : 12'h060;
            sec_next = '0;
        end else begin
            sec_next = sec_tick ? '0 : sec_cnt + 1'b1;
            if (sec_tick && cd_bcd != 12'h000) begin
                cd_next = bcd_dec(cd_bcd);
            end
        end
    end

    always_comb begin
        mode_glyph    = GLYPH_DASH;
        led_mode_next = 4'b0000;
        case (mode)
            3'b000: mode_glyph = digit_glyph(4'd0);
            3'b001: begin mode_glyph = digit_glyph(4'd1); led_mode_next = 4'b0001; end
            3'b010: begin mode_glyph = digit_glyph(4'd2); led_mode_next = 4'b0010; end
            3'b100: begin mode_glyph = digit_glyph(4'd3); led_mode_next = 4'b0100; end
            3'b111: begin mode_glyph = GLYPH_C;           led_mode_next = 4'b1000; end
            default: ;
        endcase
    end

    // Countdown digits follow the registered countdown so blanking trails cd_bcd by a cycle.
    always_comb begin
        seg_next = 8'h00;
        case (idx)
            3'd7: seg_next[6:0] = mode_glyph;
            3'd2: if (cd_d) seg_next[6:0] = digit_glyph(cd_bcd[11:8]);
            3'd1: if (cd_d) seg_next[6:0] = digit_glyph(cd_bcd[7:4]);
            3'd0: begin
                if (cd_d) seg_next[6:0] = digit_glyph(cd_bcd[3:0]);
                seg_next[7] = cleaning_reminder;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cd_d         <= 1'b0;
            cd_bcd       <= 12'h000;
            sec_cnt      <= '0;
            blink_cnt    <= '0;
            blink        <= 1'b0;
            scan_cnt     <= '0;
            idx          <= 3'd0;
            seg          <= 8'h00;
            an           <= 8'h00;
            led_mode     <= 4'b0000;
            led_reminder <= 1'b0;
        end else begin
            cd_d         <= countdown;
            cd_bcd       <= cd_next;
            sec_cnt      <= sec_next;
            blink_cnt    <= blink_wrap ? '0 : blink_cnt + 1'b1;
            if (blink_wrap) blink <= ~blink;
            scan_cnt     <= scan_wrap ? '0 : scan_cnt + 1'b1;
            if (scan_wrap) idx <= idx + 3'd1;
            seg          <= seg_next;
            an           <= 8'h01 << idx;
            led_mode     <= led_mode_next;
            led_reminder <= cleaning_reminder & blink;
        end
    end

endmodule

// File: tb/tb_hood_status_display.sv
// Directed self-checking bench for hood_status_display with SEC_DIV=10, SCAN_DIV=4.
module tb_hood_status_display;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  mode;
    logic        countdown;
    logic        cleaning_reminder;
    logic [7:0]  seg;
    logic [7:0]  an;
    logic [3:0]  led_mode;
    logic        led_reminder;
    logic [11:0] cd_bcd;

    int vectors = 0;
    int miscompares = 0;

    hood_status_display #(
        .SEC_DIV  (10),
        .SCAN_DIV (4)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .mode              (mode),
        .countdown         (countdown),
        .cleaning_reminder (cleaning_reminder),
        .seg               (seg),
        .an                (an),
        .led_mode          (led_mode),
        .led_reminder      (led_reminder),
        .cd_bcd            (cd_bcd)
    );

    always #5 clk = ~clk;

    // Advance n rising edges, then settle 1 time unit past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_an(input logic [7:0] tgt, input string tag);
        for (int i = 0; i < 64 && an !== tgt; i++) step(1);
        chk(tag, {24'h0, an}, {24'h0, tgt});
    endtask

    task automatic wait_led(input logic val, input string tag);
        for (int i = 0; i < 25 && led_reminder !== val; i++) step(1);
        chk(tag, {31'h0, led_reminder}, {31'h0, val});
    endtask

    initial begin
        logic [7:0] exp_an;

        // 1: reset values and scan order with everything idle
        reset = 1'b1;
        mode = 3'b000;
        countdown = 1'b0;
        cleaning_reminder = 1'b0;
        step(3);
        chk("rst_seg", {24'h0, seg}, 32'h0);
        chk("rst_an", {24'h0, an}, 32'h0);
        chk("rst_led_mode", {28'h0, led_mode}, 32'h0);
        chk("rst_led_rem", {31'h0, led_reminder}, 32'h0);
        chk("rst_cd", {20'h0, cd_bcd}, 32'h0);
        reset = 1'b0;
        for (int k = 0; k < 36; k++) begin
            step(1);
            exp_an = 8'h01 << ((k / 4) % 8);
            chk("scan_an", {24'h0, an}, {24'h0, exp_an});
            chk("scan_seg", {24'h0, seg}, (exp_an == 8'h80) ? 32'h3F : 32'h0);
        end

        // 2: gear 3 countdown from 060, aligned so that digit 0 is showing at the load
        mode = 3'b100;
        wait_an(8'h80, "sync2_a");
        wait_an(8'h01, "sync2_b");
        countdown = 1'b1;
        step(1);
        chk("g3_load", {20'h0, cd_bcd}, 32'h060);
        chk("g3_led_mode", {28'h0, led_mode}, 32'h4);
        step(1);
        chk("g3_d0_an", {24'h0, an}, 32'h01);
        chk("g3_d0_seg", {24'h0, seg}, 32'h3F);
        step(3);
        chk("g3_d1_an", {24'h0, an}, 32'h02);
        chk("g3_d1_seg", {24'h0, seg}, 32'h7D);
        step(4);
        chk("g3_d2_an", {24'h0, an}, 32'h04);
        chk("g3_d2_seg", {24'h0, seg}, 32'h3F);
        step(2);
        chk("g3_first_dec", {20'h0, cd_bcd}, 32'h059);
        step(589);
        chk("g3_one_left", {20'h0, cd_bcd}, 32'h001);
        step(1);
        chk("g3_zero", {20'h0, cd_bcd}, 32'h000);
        step(20);
        chk("g3_hold_zero", {20'h0, cd_bcd}, 32'h000);

        // 3: self-clean loads 180, borrow across hundreds
        countdown = 1'b0;
        mode = 3'b111;
        wait_an(8'h80, "sync3_a");
        wait_an(8'h01, "sync3_b");
        countdown = 1'b1;
        step(1);
        chk("cl_load", {20'h0, cd_bcd}, 32'h180);
        chk("cl_led_mode", {28'h0, led_mode}, 32'h8);
        step(800);
        chk("cl_80_ticks", {20'h0, cd_bcd}, 32'h100);
        step(10);
        chk("cl_81_ticks", {20'h0, cd_bcd}, 32'h099);
        wait_an(8'h80, "cl_d7_an");
        chk("cl_d7_seg", {24'h0, seg}, 32'h39);

        // 4: countdown drops mid-count at 045, then rises again
        countdown = 1'b0;
        mode = 3'b100;
        wait_an(8'h80, "sync4_a");
        wait_an(8'h01, "sync4_b");
        countdown = 1'b1;
        step(1);
        chk("mid_load", {20'h0, cd_bcd}, 32'h060);
        step(150);
        chk("mid_045", {20'h0, cd_bcd}, 32'h045);
        countdown = 1'b0;
        step(1);
        chk("mid_fall", {20'h0, cd_bcd}, 32'h000);
        wait_an(8'h02, "mid_blank_an");
        chk("mid_blank_seg", {24'h0, seg}, 32'h00);
        countdown = 1'b1;
        step(1);
        chk("mid_reload", {20'h0, cd_bcd}, 32'h060);

        // 5: reminder LED blinks with a 10-cycle half period, dp on digit 0 only
        cleaning_reminder = 1'b1;
        wait_led(1'b0, "blink_low");
        wait_led(1'b1, "blink_rise");
        step(9);
        chk("blink_hold_hi", {31'h0, led_reminder}, 32'h1);
        step(1);
        chk("blink_fall", {31'h0, led_reminder}, 32'h0);
        step(9);
        chk("blink_hold_lo", {31'h0, led_reminder}, 32'h0);
        step(1);
        chk("blink_rise2", {31'h0, led_reminder}, 32'h1);
        wait_an(8'h01, "dp_d0_an");
        chk("dp_d0", {31'h0, seg[7]}, 32'h1);
        wait_an(8'h02, "dp_d1_an");
        chk("dp_d1", {31'h0, seg[7]}, 32'h0);
        wait_led(1'b0, "rem_off_low");
        wait_led(1'b1, "rem_off_rise");
        cleaning_reminder = 1'b0;
        step(1);
        chk("rem_off", {31'h0, led_reminder}, 32'h0);

        // 6: illegal mode code, then reset in the middle of a scan at idx 5
        mode = 3'b101;
        step(1);
        chk("ill_led_mode", {28'h0, led_mode}, 32'h0);
        wait_an(8'h80, "ill_d7_an");
        chk("ill_d7_seg", {24'h0, seg}, 32'h40);
        wait_an(8'h20, "rst_mid_an");
        reset = 1'b1;
        step(1);
        chk("rst_mid_an0", {24'h0, an}, 32'h0);
        chk("rst_mid_seg", {24'h0, seg}, 32'h0);
        chk("rst_mid_cd", {20'h0, cd_bcd}, 32'h0);
        step(1);
        reset = 1'b0;
        step(1);
        chk("post_rst_an", {24'h0, an}, 32'h01);
        chk("post_rst_seg", {24'h0, seg}, 32'h00);
        chk("post_rst_reload", {20'h0, cd_bcd}, 32'h060);
        step(4);
        chk("post_rst_an2", {24'h0, an}, 32'h02);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
